bird_life_ctrl: RTL and testbench
=================================

BIRD_LIFE_CTRL -- requirements
Module: bird_life_ctrl

Interface
REQ-001 SHALL have parameter HIT_POINTS, default 3: hit points loaded on spawn, range 1..7.
REQ-002 SHALL have parameter FLASH_FRAMES, default 8: length of the post-hit invulnerable flash period, in frames, range 1..255.
REQ-003 SHALL have parameter FLAP_FRAMES, default 16: frames per duty50 half-period, range 1..255.
REQ-004 SHALL have parameter RESPAWN_FRAMES, default 64: length of the dead period before returning to IDLE, in frames, range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: system clock.
REQ-006 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port startOfFrame, input, 1 bit: one-cycle pulse once per video frame.
REQ-008 SHALL have port spawn, input, 1 bit: one-cycle request to activate the bird.
REQ-009 SHALL have port hit, input, 1 bit: one-cycle collision pulse.
REQ-010 SHALL have port kill, input, 1 bit: one-cycle request for immediate death regardless of hit points.
REQ-011 SHALL have port alive, output, 1 bit: bird is drawn.
REQ-012 SHALL have port flash, output, 1 bit: draw the bird red.
REQ-013 SHALL have port duty50, output, 1 bit: wing pose, 1 = up.
REQ-014 SHALL have port hp, output, 3 bits: remaining hit points.
REQ-015 SHALL have port died, output, 1 bit: one-cycle pulse on entry to DEAD.

Function
REQ-016 SHALL implement states IDLE, ALIVE, HURT and DEAD, plus an 8-bit frame counter cnt that is cleared on every state entry.
REQ-017 SHALL register all outputs; an input sampled at edge N SHALL be reflected on the outputs after edge N.
REQ-018 SHALL, in IDLE, hold alive=0 and hp=0, and on spawn go to ALIVE with hp=HIT_POINTS.
REQ-019 SHALL ignore spawn in ALIVE, HURT and DEAD.
REQ-020 SHALL, in ALIVE on hit, decrement hp and then go to HURT if hp>1, or go to DEAD if hp==1.
REQ-021 SHALL, in HURT, ignore hit, increment cnt on each startOfFrame, and go to ALIVE on the startOfFrame where cnt==FLASH_FRAMES-1.
REQ-022 SHALL, in ALIVE or HURT on kill, go to DEAD with hp=0; kill SHALL take priority over a simultaneous hit.
REQ-023 SHALL, in DEAD, hold alive=0 and flash=0, and go to IDLE on the startOfFrame where cnt==RESPAWN_FRAMES-1; hit and kill SHALL be ignored in DEAD.
REQ-024 SHALL assert alive=1 in ALIVE and HURT, and alive=0 otherwise.
REQ-025 SHALL assert died for exactly one cycle on each entry to DEAD.
REQ-026 SHALL use a separate flap counter that increments on startOfFrame while alive=1 and toggles duty50 when it reaches FLAP_FRAMES-1, wrapping to 0.
REQ-027 SHALL freeze duty50 and the flap counter while alive=0, and clear both on spawn.
REQ-028 SHALL, when a state transition and startOfFrame occur in the same cycle, let the transition win, so the new state's cnt starts at 0.
REQ-029 SHALL saturate hp at 0 and never wrap it.

Reset
REQ-030 SHALL asynchronously force state=IDLE, cnt=0, flap counter=0, alive=0, flash=0, duty50=0, hp=0 and died=0 while resetN=0.
REQ-031 SHALL, when reset is asserted mid-HURT or mid-DEAD, abandon the period and require a new spawn before alive rises.

Configuration
REQ-032 SHALL, with BIRD_FLASH_BLINK_EN defined, drive flash in HURT as 1 when cnt[1]==0 and 0 when cnt[1]==1, blinking every 2 frames.
REQ-033 SHALL, without BIRD_FLASH_BLINK_EN, hold flash=1 for the whole HURT state; flash SHALL be 0 outside HURT in both builds.

Verification
REQ-034 SHALL cover: reset, spawn -> alive=1 and hp=3 one cycle later, with flash=0 and duty50=0.
REQ-035 SHALL cover: hit in ALIVE -> hp=2 and flash=1; further hits ignored; alive and flash return to ALIVE/0 after the 8th startOfFrame.
REQ-036 SHALL cover: three hits, each separated by a full HURT period -> third hit gives died pulse, hp=0 and alive=0; 64 startOfFrame pulses later the state is IDLE and spawn works again.
REQ-037 SHALL cover: kill and hit in the same cycle at hp=3 -> DEAD with hp=0 and exactly one died pulse.
REQ-038 SHALL cover: 40 startOfFrame pulses while alive -> duty50 toggles at pulses 16 and 32; it then stays frozen across death.
REQ-039 SHALL cover: with BIRD_FLASH_BLINK_EN defined, a hit -> flash pattern 1,1,0,0,1,1,0,0 across the 8 HURT frames.

Source files
------------

// File: rtl/bird_life_ctrl.sv
// Bird life-cycle controller: spawn, hit points, post-hit flash, death/respawn timing and wing flap.
// Optional build macro BIRD_FLASH_BLINK_EN makes flash blink every 2 frames while HURT.
module bird_life_ctrl #(
  parameter int HIT_POINTS     = 3,
  parameter int FLASH_FRAMES   = 8,
  parameter int FLAP_FRAMES    = 16,
  parameter int RESPAWN_FRAMES = 64
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       spawn,
  input  logic       hit,
  input  logic       kill,
  output logic       alive,
  output logic       flash,
  output logic       duty50,
  output logic [2:0] hp,
  output logic       died
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIVE = 2'd1,
    HURT  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam logic [2:0] HP_INIT      = 3'(HIT_POINTS);
  localparam logic [7:0] FLASH_LAST   = 8'(FLASH_FRAMES - 1);
  localparam logic [7:0] FLAP_LAST    = 8'(FLAP_FRAMES - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [7:0] flap_cnt;
  logic [2:0] hp_n;
  logic       alive_n;
  logic       flash_n;
  logic       died_n;

  // Next-state, frame counter and hit-point update
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = hp;
    case (state)
      IDLE: begin
        hp_n = 3'd0;
        if (spawn) begin
          state_n = ALIVE;
          hp_n    = HP_INIT;
        end else begin
          state_n = IDLE;
        end
      end
      ALIVE: begin
        if (kill) begin
          state_n = DEAD;
          hp_n    = 3'd0;
        end else if (hit) begin
          // hp saturates at zero: the last hit point goes straight to DEAD
          if (hp > 3'd1) begin
            state_n = HURT;
            hp_n    = hp - 3'd1;
          end else begin
            state_n = DEAD;
            hp_n    = 3'd0;
          end
        end else begin
          state_n = ALIVE;
        end
      end
      HURT: begin
        if (kill) begin
          state_n = DEAD;
          hp_n    = 3'd0;
        end else if (startOfFrame) begin
          if (cnt == FLASH_LAST) begin
            state_n = ALIVE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n = HURT;
        end
      end
      DEAD: begin
        hp_n = 3'd0;
        if (startOfFrame) begin
          if (cnt == RESPAWN_LAST) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else begin
          state_n = DEAD;
        end
      end
      default: begin
        state_n = IDLE;
        hp_n    = 3'd0;
      end
    endcase
    // Any state entry restarts the frame count, even if a frame pulse coincides
    if (state_n != state) begin
      cnt_n = 8'd0;
    end else begin
      cnt_n = cnt_n;
    end
  end

  // Output decode from the next state so the registered outputs track it
  always_comb begin
    alive_n = (state_n == ALIVE) || (state_n == HURT);
    died_n  = (state_n == DEAD) && (state != DEAD);
    if (state_n == HURT) begin
`ifdef BIRD_FLASH_BLINK_EN
      flash_n = ~cnt_n[1];
`else
      flash_n = 1'b1;
`endif
    end else begin
      flash_n = 1'b0;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= 8'd0;
      hp    <= 3'd0;
      alive <= 1'b0;
      flash <= 1'b0;
      died  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hp    <= hp_n;
      alive <= alive_n;
      flash <= flash_n;
      died  <= died_n;
    end
  end

  // Wing flap: runs only while drawn, frozen otherwise, restarted on spawn
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flap_cnt <= 8'd0;
      duty50   <= 1'b0;
    end else if ((state == IDLE) && spawn) begin
      flap_cnt <= 8'd0;
      duty50   <= 1'b0;
    end else if (alive && startOfFrame) begin
      if (flap_cnt == FLAP_LAST) begin
        flap_cnt <= 8'd0;
        duty50   <= ~duty50;
      end else begin
        flap_cnt <= flap_cnt + 8'd1;
      end
    end else begin
      flap_cnt <= flap_cnt;
      duty50   <= duty50;
    end
  end

endmodule

// File: tb/tb_bird_life_ctrl.sv
// Self-checking bench for bird_life_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a countdown-based behavioural model.
module tb_bird_life_ctrl;

  localparam int HP0     = 3;
  localparam int FLASHF  = 8;
  localparam int FLAPF   = 16;
  localparam int RESPAWN = 64;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       spawn = 1'b0;
  logic       hit = 1'b0;
  logic       kill = 1'b0;
  logic       alive, flash, duty50, died;
  logic [2:0] hp;
  logic [6:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 alive, 2 hurt, 3 dead; left = frames remaining in timed mode
  int m_mode, m_left, m_hp, m_flap;
  bit m_duty, m_died;

  bird_life_ctrl #(
    .HIT_POINTS(HP0), .FLASH_FRAMES(FLASHF), .FLAP_FRAMES(FLAPF), .RESPAWN_FRAMES(RESPAWN)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spawn(spawn), .hit(hit),
    .kill(kill), .alive(alive), .flash(flash), .duty50(duty50), .hp(hp), .died(died)
  );

  always #5 clk = ~clk;
  assign obs = {alive, flash, duty50, hp, died};

  function automatic logic [6:0] exp_vec();
    bit a, f;
    int e;
    a = (m_mode == 1) || (m_mode == 2);
    e = FLASHF - m_left;
`ifdef BIRD_FLASH_BLINK_EN
    f = (m_mode == 2) && (((e / 2) % 2) == 0);
`else
    f = (m_mode == 2);
`endif
    return {a, f, m_duty, 3'(m_hp), m_died};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_hp = 0; m_flap = 0; m_duty = 1'b0; m_died = 1'b0;
  endtask

  task automatic model_die();
    m_mode = 3; m_hp = 0; m_left = RESPAWN; m_died = 1'b1;
  endtask

  task automatic step(input bit s, input bit h, input bit k, input bit f);
    spawn = s; hit = h; kill = k; startOfFrame = f;
    @(posedge clk);
    m_died = 1'b0;
    if (((m_mode == 1) || (m_mode == 2)) && f) begin
      m_flap++;
      if (m_flap == FLAPF) begin
        m_flap = 0;
        m_duty = ~m_duty;
      end
    end
    case (m_mode)
      0: if (s) begin m_mode = 1; m_hp = HP0; m_flap = 0; m_duty = 1'b0; end
      1: if (k) model_die();
         else if (h) begin
           m_hp--;
           if (m_hp == 0) model_die();
           else begin m_mode = 2; m_left = FLASHF; end
         end
      2: if (k) model_die();
         else if (f) begin m_left--; if (m_left == 0) m_mode = 1; end
      default: if (f) begin m_left--; if (m_left == 0) m_mode = 0; end
    endcase
    #1;
    spawn = 1'b0; hit = 1'b0; kill = 1'b0; startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs !== 7'd0) begin
      n_bad++;
      $display("FAIL reset: outputs got %b want %b", obs, 7'd0);
    end
  endtask

  task automatic test_spawn();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 3'd3, 1'b0} || obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL spawn: outputs got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_hit();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 3'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL hit_enter: outputs got %b want %b", obs, {1'b1, 1'b1, 1'b0, 3'd2, 1'b0});
    end
    for (int i = 0; i < FLASHF; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL hurt_frame%0d: outputs got %b want %b", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if ({alive, flash, hp} !== {1'b1, 1'b0, 3'd2}) begin
      n_bad++;
      $display("FAIL hurt_exit: alive/flash/hp got %b want %b", {alive, flash, hp}, {1'b1, 1'b0, 3'd2});
    end
  endtask

  task automatic test_death();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 3; h++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL death_hit%0d: outputs got %b want %b", h, obs, exp_vec());
      end
      if (h < 2) for (int i = 0; i < FLASHF; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++;
    if ({alive, hp, died} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL died_pulse: alive/hp/died got %b want %b", {alive, hp, died}, {1'b0, 3'd0, 1'b1});
    end
    for (int i = 0; i < RESPAWN; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL dead_frame%0d: outputs got %b want %b", i, obs, exp_vec());
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL respawn: outputs got %b want %b", obs, {1'b1, 1'b0, 1'b0, 3'd3, 1'b0});
    end
  endtask

  task automatic test_kill_hit();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL kill_hit: outputs got %b want %b", obs, {1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (obs !== exp_vec() || died !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_single_pulse: outputs got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_flap();
    logic [1:0] toggles;
    bit prev;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    toggles = 2'd0;
    prev = duty50;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (duty50 !== prev) begin
        n_cmp++;
        if (!(i == 16 || i == 32)) begin
          n_bad++;
          $display("FAIL flap_toggle: toggled at pulse %0d want 16 or 32", i);
        end
        toggles++;
      end
      prev = duty50;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL flap_pulse%0d: outputs got %b want %b", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (toggles !== 2'd2) begin
      n_bad++;
      $display("FAIL flap_count: toggles got %0d want 2", toggles);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (duty50 !== 1'b0 || obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL flap_frozen%0d: outputs got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_flash_pattern();
    logic [7:0] pat;
`ifdef BIRD_FLASH_BLINK_EN
    pat = 8'b1100_1100;
`else
    pat = 8'b1111_1111;
`endif
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < FLASHF; i++) begin
      n_cmp++;
      if (flash !== pat[7-i]) begin
        n_bad++;
        $display("FAIL flash_frame%0d: flash got %b want %b", i, flash, pat[7-i]);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_cmp++;
    if (flash !== 1'b0) begin
      n_bad++;
      $display("FAIL flash_after: flash got %b want 0", flash);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== 7'd0) begin
        n_bad++;
        $display("FAIL reset_mid%0d: outputs got %b want %b", i, obs, 7'd0);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_mid_spawn: outputs got %b want %b", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(9) == 0),
           ($urandom_range(39) == 0), ($urandom_range(2) == 0));
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL random%0d: outputs got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn();
    test_hit();
    test_death();
    test_kill_hit();
    test_flap();
    test_flash_pattern();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
